sram_mem_ctrl: RTL and testbench
================================

# sram_mem_ctrl

- Memory-stage sequencer between the EX/MEM pipeline register and the external 16-bit SRAM.
- Each 32-bit load/store is split into two half-word SRAM accesses: low half first, then high half.
- Each half-word access lasts a programmable number of wait cycles.
- `ready` is driven low while an access is in progress, which freezes every pipeline register, including EX/MEM.
- Read data is held in a register for the MEM/WB stage.

## Interface
- `WAIT_STATES`, default 1: cycles each half-word phase is held. Legal range 1..15.
- `ADDR_W`, default 18: SRAM half-word address width.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_read` in 1: load request from EX/MEM.
- `mem_write` in 1: store request from EX/MEM.
- `address` in 32: byte address, taken from the EX/MEM ALU result.
- `wdata` in 32: store data, taken from the EX/MEM Rm value.
- `rdata` out 32: registered load data.
- `ready` out 1: 0 freezes the pipeline.
- `sram_addr` out ADDR_W: SRAM half-word address.
- `sram_dq_out` out 16: write data driven to the SRAM.
- `sram_dq_oe` out 1: 1 means the controller drives the data bus.
- `sram_dq_in` in 16: data bus as sampled by the controller.
- `sram_we_n` out 1: active-low SRAM write enable.

## Operation
**States:** IDLE, LOW, HIGH, DONE. A 4-bit `cnt` counts the wait cycles within a phase.

**IDLE**
- If `mem_read` or `mem_write` is 1 at the clock edge: latch `is_write = mem_write`, clear `cnt` to 0, go to LOW.
- If both inputs are 1, the access is a write.
- Otherwise stay in IDLE.

**LOW**
- `sram_addr = {address[ADDR_W:2], 1'b0}`.
- Write: `sram_dq_out = wdata[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0`.
- Read: `sram_dq_oe = 0`, `sram_we_n = 1`.
- `cnt` increments each cycle.
- On the cycle where `cnt == WAIT_STATES-1`:
  - a read captures `sram_dq_in` into `rdata[15:0]`;
  - `cnt` clears to 0 and the state moves to HIGH.

**HIGH**
- Same as LOW, with these changes:
  - the address LSB is 1;
  - write data is `wdata[31:16]`;
  - a read captures into `rdata[31:16]`.
- On the last cycle the state moves to DONE.

**DONE**
- SRAM is idle.
- Go to IDLE unconditionally.

**Idle SRAM values** (in IDLE and DONE): `sram_addr = 0`, `sram_dq_out = 0`, `sram_dq_oe = 0`, `sram_we_n = 1`.

**Outputs**
- `ready = (state == IDLE && !mem_read && !mem_write) || state == DONE`. This is combinational, so a request arriving in IDLE freezes the pipeline in that same cycle.
- SRAM controls are decoded from the state and `is_write` only.
- SRAM address and data are driven from `address`/`wdata`, which EX/MEM holds stable while `ready = 0`.

**Other rules**
- Once the FSM leaves IDLE, `mem_read`/`mem_write` are ignored until it returns to IDLE.
- `rdata` changes only on read captures. Writes never modify it.
- `address[1:0]` and `address[31:ADDR_W+1]` are ignored.

## Timing
**Reset**
- `rst = 0` asynchronously forces: state IDLE, `cnt = 0`, `is_write = 0`, `rdata = 0`, and all SRAM outputs to their idle values.
- While `rst = 0`, `ready` follows the combinational rule above.
- Reset asserted mid-access aborts the access at once. A write may be left half-done.
- If `rst` deasserts while a request is already high, the access starts at the first rising edge after deassertion.

**Latency.** A request first seen in IDLE in cycle 0 proceeds as follows (W = `WAIT_STATES`):
- LOW occupies cycles 1..W.
- HIGH occupies cycles W+1..2W.
- DONE is cycle 2W+1.
- `ready` is 0 in cycles 0..2W and 1 in cycle 2W+1.
- For a read, `rdata` is valid from cycle 2W+1 onward and holds until the next read.

**Back-to-back accesses.** The pipeline advances at the end of DONE. A following memory instruction is seen in IDLE at cycle 2W+2. `ready` is 1 for exactly one cycle between the two accesses.

**No-request cycles.** With no request, `ready` stays 1 and the SRAM remains idle.

## Test plan
- **Reset:** hold `rst = 0` with `mem_write = 1`.
  - Expect `sram_we_n = 1`, `sram_dq_oe = 0`, `rdata = 0`, state IDLE, `ready = 0`.
  - Release `rst`: the access starts on the next edge.
- **Write, W = 1:** `address = 0x00000408`, `wdata = 0xDEADBEEF`.
  - Cycle 1: `sram_addr = 0x204`, `dq = 0xBEEF`, `we_n = 0`.
  - Cycle 2: `sram_addr = 0x205`, `dq = 0xDEAD`.
  - `ready` is 0 in cycles 0..2 and 1 in cycle 3.
- **Read, W = 1:** SRAM model holds `0x204 = 0x5678` and `0x205 = 0x1234`; request a read of `address = 0x408`.
  - `rdata = 0x12345678` in cycle 3.
  - A later write leaves `rdata` unchanged.
- **Wait states, W = 3:** a write-then-read pair.
  - Each phase holds its address for 3 cycles.
  - `ready` is low for 7 cycles per access.
  - `rdata` matches the data written.
- **Back-to-back reads** to `0x408` then `0x40C`:
  - `ready` pattern is 0,0,0,1,0,0,0,1.
  - The second read drives `sram_addr` 0x206 then 0x207.
- **Reset mid-access and no-op:**
  - Assert `rst` during the HIGH phase of a write: `we_n` goes to 1 and `oe` to 0 immediately, and the FSM is in IDLE.
  - With `mem_read = mem_write = 0`, `ready` stays 1 for 10 cycles and the SRAM stays idle.

Source files
------------

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: memory-stage sequencer that turns one 32-bit load/store
// into two 16-bit SRAM accesses (low half, then high half), each held for
// WAIT_STATES cycles, while stalling the pipeline through 'ready'.
module sram_mem_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [3:0]  r_cnt;
  logic        r_isWrite;
  logic [31:0] r_rdata;
  logic        w_request;
  logic        w_lastCnt;
  logic        w_unusedAddr;

  // Byte-offset bits and bits above the SRAM range are deliberately dropped.
  assign w_unusedAddr = &{1'b0, address[31:ADDR_W+1], address[1:0]};

  assign w_request = mem_read | mem_write;
  assign w_lastCnt = (r_cnt == LAST_CNT);
  assign rdata     = r_rdata;

  // Ready is combinational so a fresh request stalls the pipeline in the same cycle.
  assign ready = ((r_state == IDLE) && !w_request) || (r_state == DONE);

  // State register; reset aborts any access in flight immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Wait counter, access direction latch and the two read-capture halves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= 4'd0;
      r_isWrite <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_request) begin
            r_isWrite <= mem_write;
            r_cnt     <= 4'd0;
          end
        end
        LOW: begin
          if (w_lastCnt) begin
            r_cnt <= 4'd0;
            if (!r_isWrite) r_rdata[15:0] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        HIGH: begin
          if (w_lastCnt) begin
            r_cnt <= 4'd0;
            if (!r_isWrite) r_rdata[31:16] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and SRAM control decode; SRAM is idle unless in LOW or HIGH.
  always_comb begin
    w_stateNext = r_state;
    sram_addr   = '0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_request) w_stateNext = LOW;
      end
      LOW: begin
        sram_addr = {address[ADDR_W:2], 1'b0};
        if (r_isWrite) begin
          sram_dq_out = wdata[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (w_lastCnt) w_stateNext = HIGH;
      end
      HIGH: begin
        sram_addr = {address[ADDR_W:2], 1'b1};
        if (r_isWrite) begin
          sram_dq_out = wdata[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (w_lastCnt) w_stateNext = DONE;
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: directed bench for sram_mem_ctrl with a W=1 and a W=3
// instance sharing one stimulus, each backed by its own small SRAM model.
module tb_sram_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] wdata;

  logic [31:0] rdata1, rdata3;
  logic        ready1, ready3;
  logic [17:0] addr1, addr3;
  logic [15:0] dqOut1, dqOut3;
  logic        dqOe1, dqOe3;
  logic [15:0] dqIn1, dqIn3;
  logic        weN1, weN3;

  logic [15:0] mem1 [0:1023];
  logic [15:0] mem3 [0:1023];

  int checks = 0;
  int errors = 0;

  sram_mem_ctrl #(.WAIT_STATES(1), .ADDR_W(18)) dut1 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .wdata(wdata), .rdata(rdata1), .ready(ready1),
    .sram_addr(addr1), .sram_dq_out(dqOut1), .sram_dq_oe(dqOe1),
    .sram_dq_in(dqIn1), .sram_we_n(weN1)
  );

  sram_mem_ctrl #(.WAIT_STATES(3), .ADDR_W(18)) dut3 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .wdata(wdata), .rdata(rdata3), .ready(ready3),
    .sram_addr(addr3), .sram_dq_out(dqOut3), .sram_dq_oe(dqOe3),
    .sram_dq_in(dqIn3), .sram_we_n(weN3)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read, synchronous-write SRAM models.
  assign dqIn1 = mem1[addr1[9:0]];
  assign dqIn3 = mem3[addr3[9:0]];

  always @(posedge clk) begin
    if (!weN1) mem1[addr1[9:0]] <= dqOut1;
    if (!weN3) mem3[addr3[9:0]] <= dqOut3;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance to the sampling point in the middle of the next cycle.
  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Drive a request and its operands.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    mem_read  = rd;
    mem_write = wr;
    address   = addr;
    wdata     = data;
  endtask

  // Pulse reset across a couple of edges with no request pending.
  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 16'h0000;
      mem3[i] = 16'h0000;
    end

    // Reset held with a write pending: SRAM idle, pipeline stalled.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF);
    nextCycle();
    nextCycle();
    checkOutput("rst_we_n",  {31'd0, weN1},  32'd1);
    checkOutput("rst_oe",    {31'd0, dqOe1}, 32'd0);
    checkOutput("rst_rdata", rdata1,         32'd0);
    checkOutput("rst_addr",  {14'd0, addr1}, 32'd0);
    checkOutput("rst_ready", {31'd0, ready1}, 32'd0);

    // Release reset: this cycle is cycle 0 of the write (W=1).
    rst = 1'b1;
    #1;
    checkOutput("wr1_c0_ready", {31'd0, ready1}, 32'd0);
    nextCycle();
    checkOutput("wr1_c1_addr",  {14'd0, addr1},  32'h204);
    checkOutput("wr1_c1_dq",    {16'd0, dqOut1}, 32'hBEEF);
    checkOutput("wr1_c1_we_n",  {31'd0, weN1},   32'd0);
    checkOutput("wr1_c1_oe",    {31'd0, dqOe1},  32'd1);
    checkOutput("wr1_c1_ready", {31'd0, ready1}, 32'd0);
    nextCycle();
    checkOutput("wr1_c2_addr",  {14'd0, addr1},  32'h205);
    checkOutput("wr1_c2_dq",    {16'd0, dqOut1}, 32'hDEAD);
    checkOutput("wr1_c2_we_n",  {31'd0, weN1},   32'd0);
    checkOutput("wr1_c2_ready", {31'd0, ready1}, 32'd0);
    nextCycle();
    checkOutput("wr1_c3_ready", {31'd0, ready1}, 32'd1);
    checkOutput("wr1_c3_we_n",  {31'd0, weN1},   32'd1);
    checkOutput("wr1_c3_addr",  {14'd0, addr1},  32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("wr1_mem_lo", {16'd0, mem1[10'h204]}, 32'hBEEF);
    checkOutput("wr1_mem_hi", {16'd0, mem1[10'h205]}, 32'hDEAD);

    // Read (W=1) from a preloaded location.
    doReset();
    mem1[10'h204] = 16'h5678;
    mem1[10'h205] = 16'h1234;
    applyStimulus(1'b1, 1'b0, 32'h0000_0408, 32'd0);
    #1;
    checkOutput("rd1_c0_ready", {31'd0, ready1}, 32'd0);
    nextCycle();
    checkOutput("rd1_c1_addr", {14'd0, addr1}, 32'h204);
    checkOutput("rd1_c1_oe",   {31'd0, dqOe1}, 32'd0);
    checkOutput("rd1_c1_we_n", {31'd0, weN1},  32'd1);
    nextCycle();
    checkOutput("rd1_c2_addr", {14'd0, addr1}, 32'h205);
    nextCycle();
    checkOutput("rd1_c3_ready", {31'd0, ready1}, 32'd1);
    checkOutput("rd1_c3_rdata", rdata1, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    nextCycle();

    // A following write must leave rdata untouched.
    applyStimulus(1'b0, 1'b1, 32'h0000_0500, 32'hAAAA_5555);
    for (int c = 0; c < 4; c++) nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("rd1_hold_after_wr", rdata1, 32'h1234_5678);

    // Back-to-back reads (W=1): 0x408 then 0x40C.
    doReset();
    mem1[10'h204] = 16'h5678;
    mem1[10'h205] = 16'h1234;
    mem1[10'h206] = 16'h3344;
    mem1[10'h207] = 16'h1122;
    applyStimulus(1'b1, 1'b0, 32'h0000_0408, 32'd0);
    #1;
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("b2b_ready_c%0d", c), {31'd0, ready1},
                  ((c == 3) || (c == 7)) ? 32'd1 : 32'd0);
      if (c == 3) begin
        checkOutput("b2b_rdata_first", rdata1, 32'h1234_5678);
        address = 32'h0000_040C;
      end
      if (c == 5) checkOutput("b2b_c5_addr", {14'd0, addr1}, 32'h206);
      if (c == 6) checkOutput("b2b_c6_addr", {14'd0, addr1}, 32'h207);
      if (c == 7) begin
        checkOutput("b2b_rdata_second", rdata1, 32'h1122_3344);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      end
      nextCycle();
    end

    // Wait states (W=3): write then read back the same word.
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h0000_0408, 32'hCAFE_F00D);
    #1;
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("w3_wr_ready_c%0d", c), {31'd0, ready3},
                  (c == 7) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 3) begin
        checkOutput($sformatf("w3_wr_addr_c%0d", c), {14'd0, addr3}, 32'h204);
        checkOutput($sformatf("w3_wr_dq_c%0d", c), {16'd0, dqOut3}, 32'hF00D);
      end
      if (c >= 4 && c <= 6) begin
        checkOutput($sformatf("w3_wr_addr_c%0d", c), {14'd0, addr3}, 32'h205);
        checkOutput($sformatf("w3_wr_dq_c%0d", c), {16'd0, dqOut3}, 32'hCAFE);
      end
      if (c == 7) applyStimulus(1'b1, 1'b0, 32'h0000_0408, 32'd0);
      nextCycle();
    end
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("w3_rd_ready_c%0d", c), {31'd0, ready3},
                  (c == 7) ? 32'd1 : 32'd0);
      if (c == 7) begin
        checkOutput("w3_rd_rdata", rdata3, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      end
      nextCycle();
    end

    // Reset during the HIGH phase of a write (W=1) aborts immediately.
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h0000_0408, 32'h0102_0304);
    nextCycle();
    nextCycle();
    checkOutput("abort_pre_we_n", {31'd0, weN1},  32'd0);
    checkOutput("abort_pre_addr", {14'd0, addr1}, 32'h205);
    rst = 1'b0;
    #1;
    checkOutput("abort_we_n",  {31'd0, weN1},   32'd1);
    checkOutput("abort_oe",    {31'd0, dqOe1},  32'd0);
    checkOutput("abort_addr",  {14'd0, addr1},  32'd0);
    checkOutput("abort_ready", {31'd0, ready1}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("abort_idle_ready", {31'd0, ready1}, 32'd1);
    nextCycle();
    rst = 1'b1;

    // No requests: ready stays high and the SRAM stays idle.
    for (int c = 0; c < 10; c++) begin
      nextCycle();
      checkOutput($sformatf("noop_ready_c%0d", c), {31'd0, ready1}, 32'd1);
      checkOutput($sformatf("noop_we_n_c%0d", c), {31'd0, weN1}, 32'd1);
      checkOutput($sformatf("noop_addr_c%0d", c), {14'd0, addr1}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
